// File: rtl/i2c_target_rtl_pkg.sv
// Shared types and constants for the I2C target front end.
// Latency: n/a (declarations only).
// Backpressure: n/a (declarations only).
package i2c_rtl_pkg;

    localparam int I2C_ADDR_WIDTH = 7;
    localparam int I2C_DATA_WIDTH = 8;

    typedef enum logic [3:0] {
        ST_IDLE,
        ST_ADDR,
        ST_ADDR_ACK,
        ST_WR_BYTE,
        ST_WR_ACK,
        ST_RD_LOAD,
        ST_RD_BYTE,
        ST_RD_ACK_CHK,
        ST_IGNORE
    } i2c_state_e;

    // Value of the R/W bit that follows the address.
    typedef enum logic {
        I2C_OP_WRITE = 1'b0,
        I2C_OP_READ  = 1'b1
    } i2c_op_t;

endpackage

// File: rtl/i2c_target_rtl_if.sv
// Bus-pin and byte-stream bundle between the I2C target and its surroundings.
// Latency: n/a (wires only).
// Backpressure: rd_valid_i/rd_ready_o handshake; write stream has no backpressure.
// Ports: scl/sda wired-AND levels in, pull-down requests out; wr_* write byte
// strobe out; rd_* read byte handshake; start/stop strobes, rw and busy status.
interface i2c_target_rtl_if
    import i2c_rtl_pkg::*;
#(
    parameter int DATA_WIDTH = I2C_DATA_WIDTH
) ();
    logic                  scl_i;
    logic                  sda_i;
    logic                  scl_o;
    logic                  sda_o;
    logic [DATA_WIDTH-1:0] wr_data_o;
    logic                  wr_valid_o;
    logic [DATA_WIDTH-1:0] rd_data_i;
    logic                  rd_valid_i;
    logic                  rd_ready_o;
    logic                  start_o;
    logic                  stop_o;
    logic                  rw_o;
    logic                  busy_o;

    // Target side.
    modport slave (
        input  scl_i, sda_i, rd_data_i, rd_valid_i,
        output scl_o, sda_o, wr_data_o, wr_valid_o, rd_ready_o,
               start_o, stop_o, rw_o, busy_o
    );

    // Bus master / local logic side.
    modport master (
        output scl_i, sda_i, rd_data_i, rd_valid_i,
        input  scl_o, sda_o, wr_data_o, wr_valid_o, rd_ready_o,
               start_o, stop_o, rw_o, busy_o
    );
endinterface

// File: rtl/i2c_target_rtl_line_filter.sv
// Synchronises one open-drain line, rejects glitches, emits edge strobes.
// Latency: 2 + FILTER_LEN cycles from pin change to level_o/edge strobe.
// Backpressure: none; free-running.
// Ports: clk_i/rst_i; line_i raw pin; level_o filtered level; rise_o/fall_o
// one-cycle strobes coincident with the new level.
module i2c_line_filter #(
    parameter int FILTER_LEN = 3
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic line_i,
    output logic level_o,
    output logic rise_o,
    output logic fall_o
);
    localparam int CW = $clog2(FILTER_LEN + 1);

    logic          sync1_q, sync2_q, level_q, rise_q, fall_q;
    logic [CW-1:0] cnt_q;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            sync1_q <= 1'b1;
            sync2_q <= 1'b1;
            level_q <= 1'b1;
            rise_q  <= 1'b0;
            fall_q  <= 1'b0;
            cnt_q   <= '0;
        end else begin
            sync1_q <= line_i;
            sync2_q <= sync1_q;
            rise_q  <= 1'b0;
            fall_q  <= 1'b0;
            // Count consecutive samples that disagree with the accepted level;
            // any agreeing sample restarts the count, killing short glitches.
            if (sync2_q == level_q) begin
                cnt_q <= '0;
            end else if (cnt_q == CW'(FILTER_LEN - 1)) begin
                level_q <= sync2_q;
                rise_q  <= sync2_q;
                fall_q  <= ~sync2_q;
                cnt_q   <= '0;
            end else begin
                cnt_q <= cnt_q + CW'(1);
            end
        end
    end

    assign level_o = level_q;
    assign rise_o  = rise_q;
    assign fall_o  = fall_q;
endmodule

// File: rtl/i2c_target_rtl.sv
// I2C target: START/STOP decode, 7-bit address match, byte write/read streams.
// Latency: 2+FILTER_LEN cycles pin-to-decision; sda_o moves SDA_HOLD cycles after filtered SCL fall.
// Backpressure: read side stretches SCL while rd_valid_i is low; write side has none.
// Ports: clk_i/rst_i (async, active-high); bus = slave modport of i2c_target_rtl_if.
module i2c_target_rtl
    import i2c_rtl_pkg::*;
#(
    parameter int                    ADDR_WIDTH  = I2C_ADDR_WIDTH,
    parameter int                    DATA_WIDTH  = I2C_DATA_WIDTH,
    parameter logic [ADDR_WIDTH-1:0] TARGET_ADDR = 7'h22,
    parameter int                    FILTER_LEN  = 3,
    parameter int                    SDA_HOLD    = 4
) (
    input  logic            clk_i,
    input  logic            rst_i,
    i2c_target_rtl_if.slave bus
);
    localparam int HCW = $clog2(SDA_HOLD + 1);
    // Loaded on the fall-strobe cycle so the new sda_o appears exactly SDA_HOLD later.
    localparam logic [HCW-1:0] HOLD_LOAD = HCW'(SDA_HOLD - 1);

    logic scl_lvl, scl_rise, scl_fall, sda_lvl, sda_rise, sda_fall;

    i2c_line_filter #(.FILTER_LEN(FILTER_LEN)) u_scl_filt (
        .clk_i(clk_i), .rst_i(rst_i), .line_i(bus.scl_i),
        .level_o(scl_lvl), .rise_o(scl_rise), .fall_o(scl_fall)
    );
    i2c_line_filter #(.FILTER_LEN(FILTER_LEN)) u_sda_filt (
        .clk_i(clk_i), .rst_i(rst_i), .line_i(bus.sda_i),
        .level_o(sda_lvl), .rise_o(sda_rise), .fall_o(sda_fall)
    );

    i2c_state_e            state_q, state_d;
    logic [2:0]            bit_cnt_q, bit_cnt_d;
    logic [DATA_WIDTH-1:0] shift_q, shift_d, wr_data_q, wr_data_d;
    logic [HCW-1:0]        hold_q, hold_d;
    logic                  sda_q, sda_d, scl_q, scl_d, pend_q, pend_d;
    logic                  rel_q, rel_d, phase_q, phase_d, busy_q, busy_d;
    logic                  wr_vld_q, wr_vld_d, rd_rdy_q, rd_rdy_d;
    logic                  start_q, start_d, stop_q, stop_d;
    i2c_op_t               rw_q, rw_d;
    logic [DATA_WIDTH-1:0] sampled;
    logic                  start_det, stop_det;

    assign start_det = sda_fall & scl_lvl;
    assign stop_det  = sda_rise & scl_lvl;
    assign sampled   = {shift_q[DATA_WIDTH-2:0], sda_lvl};

    always_comb begin
        state_d   = state_q;
        bit_cnt_d = bit_cnt_q;
        shift_d   = shift_q;
        wr_data_d = wr_data_q;
        hold_d    = hold_q;
        sda_d     = sda_q;
        scl_d     = scl_q;
        pend_d    = pend_q;
        rel_d     = rel_q;
        phase_d   = phase_q;
        busy_d    = busy_q;
        rw_d      = rw_q;
        wr_vld_d  = 1'b0;
        rd_rdy_d  = 1'b0;
        start_d   = 1'b0;
        stop_d    = 1'b0;

        // SDA hold timer; once it has expired, a pending stretch release frees
        // SCL one cycle after the first read bit is already on the line.
        if (hold_q != '0) begin
            hold_d = hold_q - HCW'(1);
            if (hold_q == HCW'(1)) sda_d = pend_q;
        end else if (rel_q) begin
            scl_d = 1'b1;
            rel_d = 1'b0;
        end

        case (state_q)
            ST_ADDR: if (scl_rise) begin
                shift_d   = sampled;
                bit_cnt_d = bit_cnt_q + 3'd1;
                if (bit_cnt_q == 3'd7) begin
                    phase_d = 1'b0;
                    if (sampled[DATA_WIDTH-1 -: ADDR_WIDTH] == TARGET_ADDR) begin
                        state_d = ST_ADDR_ACK;
                        rw_d    = i2c_op_t'(sampled[0]);
                    end else begin
                        state_d = ST_IGNORE;
                    end
                end
            end
            // First fall (end of last data bit) pulls SDA for ACK; second fall
            // (end of ACK bit) releases it and moves on.
            ST_ADDR_ACK, ST_WR_ACK: if (scl_fall) begin
                hold_d = HOLD_LOAD;
                if (!phase_q) begin
                    pend_d  = 1'b0;
                    phase_d = 1'b1;
                end else begin
                    pend_d    = 1'b1;
                    phase_d   = 1'b0;
                    bit_cnt_d = 3'd0;
                    state_d   = (state_q == ST_ADDR_ACK && rw_q == I2C_OP_READ)
                                ? ST_RD_LOAD : ST_WR_BYTE;
                end
            end
            ST_WR_BYTE: if (scl_rise) begin
                shift_d   = sampled;
                bit_cnt_d = bit_cnt_q + 3'd1;
                if (bit_cnt_q == 3'd7) begin
                    wr_data_d = sampled;
                    wr_vld_d  = 1'b1;
                    phase_d   = 1'b0;
                    state_d   = ST_WR_ACK;
                end
            end
            ST_RD_LOAD: begin
                if (bus.rd_valid_i) begin
                    rd_rdy_d  = 1'b1;
                    shift_d   = bus.rd_data_i;
                    pend_d    = bus.rd_data_i[DATA_WIDTH-1];
                    bit_cnt_d = 3'd0;
                    phase_d   = 1'b0;
                    state_d   = ST_RD_BYTE;
                    // Only a stretched load restarts the hold timer; otherwise
                    // the timer started at the SCL fall is still running.
                    if (!scl_q) begin
                        hold_d = HOLD_LOAD;
                        rel_d  = 1'b1;
                    end
                end else begin
                    scl_d = 1'b0;
                end
            end
            ST_RD_BYTE: begin
                if (scl_rise) begin
                    bit_cnt_d = bit_cnt_q + 3'd1;
                    if (bit_cnt_q == 3'd7) phase_d = 1'b1;
                end
                if (scl_fall) begin
                    hold_d = HOLD_LOAD;
                    if (phase_q) begin
                        pend_d  = 1'b1;
                        phase_d = 1'b0;
                        state_d = ST_RD_ACK_CHK;
                    end else begin
                        pend_d  = shift_q[DATA_WIDTH-2];
                        shift_d = {shift_q[DATA_WIDTH-2:0], 1'b0};
                    end
                end
            end
            ST_RD_ACK_CHK: begin
                if (scl_rise) begin
                    if (sda_lvl) state_d = ST_IGNORE;
                    else         phase_d = 1'b1;
                end
                if (scl_fall && phase_q) begin
                    hold_d  = HOLD_LOAD;
                    pend_d  = 1'b1;
                    phase_d = 1'b0;
                    state_d = ST_RD_LOAD;
                end
            end
            default: ;
        endcase

        // Bus conditions win over any edge handled above in the same cycle.
        if (stop_det || start_det) begin
            sda_d     = 1'b1;
            scl_d     = 1'b1;
            hold_d    = '0;
            rel_d     = 1'b0;
            phase_d   = 1'b0;
            bit_cnt_d = 3'd0;
            wr_vld_d  = 1'b0;
            rd_rdy_d  = 1'b0;
            busy_d    = start_det;
            start_d   = start_det;
            stop_d    = ~start_det;
            state_d   = start_det ? ST_ADDR : ST_IDLE;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q   <= ST_IDLE;
            bit_cnt_q <= 3'd0;
            shift_q   <= '0;
            wr_data_q <= '0;
            hold_q    <= '0;
            sda_q     <= 1'b1;
            scl_q     <= 1'b1;
            pend_q    <= 1'b1;
            rel_q     <= 1'b0;
            phase_q   <= 1'b0;
            busy_q    <= 1'b0;
            rw_q      <= I2C_OP_WRITE;
            wr_vld_q  <= 1'b0;
            rd_rdy_q  <= 1'b0;
            start_q   <= 1'b0;
            stop_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            bit_cnt_q <= bit_cnt_d;
            shift_q   <= shift_d;
            wr_data_q <= wr_data_d;
            hold_q    <= hold_d;
            sda_q     <= sda_d;
            scl_q     <= scl_d;
            pend_q    <= pend_d;
            rel_q     <= rel_d;
            phase_q   <= phase_d;
            busy_q    <= busy_d;
            rw_q      <= rw_d;
            wr_vld_q  <= wr_vld_d;
            rd_rdy_q  <= rd_rdy_d;
            start_q   <= start_d;
            stop_q    <= stop_d;
        end
    end

    assign bus.scl_o      = scl_q;
    assign bus.sda_o      = sda_q;
    assign bus.wr_data_o  = wr_data_q;
    assign bus.wr_valid_o = wr_vld_q;
    assign bus.rd_ready_o = rd_rdy_q;
    assign bus.start_o    = start_q;
    assign bus.stop_o     = stop_q;
    assign bus.rw_o       = (rw_q == I2C_OP_READ);
    assign bus.busy_o     = busy_q;
endmodule

// File: tb/tb_i2c_target_rtl.sv
// Directed bench: bus master model on wired-AND SCL/SDA, local read-data feeder.
// Latency: n/a.
// Backpressure: master waits (bounded) while the target stretches SCL.
module tb_i2c_target_rtl;
    import i2c_rtl_pkg::*;

    localparam int Q     = 25;    // quarter SCL period in clk cycles
    localparam int BOUND = 4000;  // max cycles to wait on any DUT event

    logic clk = 1'b0;
    logic rst;
    logic scl_m, sda_m;
    always #5 clk = ~clk;

    i2c_target_rtl_if bus ();
    assign bus.scl_i = scl_m & bus.scl_o;
    assign bus.sda_i = sda_m & bus.sda_o;

    i2c_target_rtl #(.TARGET_ADDR(7'h22)) dut (
        .clk_i(clk),
        .rst_i(rst),
        .bus  (bus.slave)
    );

    // Activity monitor (sampled on the falling clock edge).
    int n_wr = 0, n_rdy = 0, n_start = 0, n_stop = 0, n_sda_low = 0;
    int cur_run = 0, max_run = 0, n_busy_on_stop = 0;
    logic [7:0] last_wr = 8'h00;
    always @(negedge clk) begin
        if (bus.wr_valid_o) begin n_wr++; last_wr = bus.wr_data_o; end
        if (bus.rd_ready_o) n_rdy++;
        if (bus.start_o) n_start++;
        if (bus.stop_o) begin n_stop++; if (bus.busy_o) n_busy_on_stop++; end
        if (!bus.sda_o) n_sda_low++;
        if (!bus.scl_o) begin cur_run++; if (cur_run > max_run) max_run = cur_run; end
        else cur_run = 0;
    end

    int n_chk = 0, n_pass = 0, n_timeout = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
    endtask

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic wait_scl_high();
        int t = 0;
        while (bus.scl_i !== 1'b1 && t < BOUND) begin @(negedge clk); t++; end
        if (t >= BOUND) n_timeout++;
    endtask

    task automatic wait_rdy();
        int t = 0;
        while (bus.rd_ready_o !== 1'b1 && t < BOUND) begin @(negedge clk); t++; end
        if (t >= BOUND) n_timeout++;
        tick(1);
    endtask

    task automatic bus_start();
        sda_m = 1'b1; tick(Q); scl_m = 1'b1; wait_scl_high(); tick(Q);
        sda_m = 1'b0; tick(Q); scl_m = 1'b0; tick(Q);
    endtask

    task automatic bus_stop();
        sda_m = 1'b0; tick(Q); scl_m = 1'b1; wait_scl_high(); tick(Q);
        sda_m = 1'b1; tick(Q);
    endtask

    task automatic write_bit(input logic b);
        sda_m = b; tick(Q); scl_m = 1'b1; wait_scl_high(); tick(2 * Q);
        scl_m = 1'b0; tick(Q);
    endtask

    task automatic read_bit(output logic b);
        sda_m = 1'b1; tick(Q); scl_m = 1'b1; wait_scl_high(); tick(Q);
        b = bus.sda_i; tick(Q);
        scl_m = 1'b0; tick(Q);
    endtask

    task automatic write_byte(input logic [7:0] d, output logic ack);
        for (int i = 7; i >= 0; i--) write_bit(d[i]);
        read_bit(ack);
    endtask

    task automatic read_byte(input logic ack, output logic [7:0] d);
        for (int i = 7; i >= 0; i--) read_bit(d[i]);
        write_bit(ack);
    endtask

    initial begin
        logic       ack;
        logic [7:0] d, d2;
        int s_wr, s_rdy, s_start, s_stop, s_sda;

        rst = 1'b1; scl_m = 1'b1; sda_m = 1'b1;
        bus.rd_valid_i = 1'b0; bus.rd_data_i = 8'h00;
        tick(5);
        // Reset state
        check("rst_scl_o", bus.scl_o, 1);
        check("rst_sda_o", bus.sda_o, 1);
        check("rst_wr_valid", bus.wr_valid_o, 0);
        check("rst_wr_data", bus.wr_data_o, 0);
        check("rst_rw", bus.rw_o, 0);
        check("rst_busy", bus.busy_o, 0);
        check("rst_strobes", {bus.start_o, bus.stop_o, bus.rd_ready_o}, 0);
        rst = 1'b0;
        tick(10);

        // Write 0xA5 to 0x22
        s_wr = n_wr; s_start = n_start; s_stop = n_stop;
        bus_start();
        check("wr_busy_after_start", bus.busy_o, 1);
        write_byte({7'h22, I2C_OP_WRITE}, ack);
        check("wr_addr_ack", ack, 0);
        write_byte(8'hA5, ack);
        check("wr_data_ack", ack, 0);
        bus_stop();
        tick(10);
        check("wr_valid_count", n_wr - s_wr, 1);
        check("wr_data", last_wr, 8'hA5);
        check("wr_start_count", n_start - s_start, 1);
        check("wr_stop_count", n_stop - s_stop, 1);
        check("wr_busy_after_stop", bus.busy_o, 0);
        check("wr_rw", bus.rw_o, 0);

        // Read 0x3C, data ready before START: no stretch
        bus.rd_data_i = 8'h3C; bus.rd_valid_i = 1'b1;
        s_rdy = n_rdy;
        bus_start();
        write_byte({7'h22, I2C_OP_READ}, ack);
        check("rd_addr_ack", ack, 0);
        check("rd_rw", bus.rw_o, 1);
        read_byte(1'b1, d);
        bus_stop();
        bus.rd_valid_i = 1'b0;
        tick(10);
        check("rd_data", d, 8'h3C);
        check("rd_ready_count", n_rdy - s_rdy, 1);
        check("rd_no_stretch", max_run, 0);

        // Read with data arriving 500 cycles after the address ACK
        s_rdy = n_rdy;
        bus_start();
        write_byte({7'h22, I2C_OP_READ}, ack);
        check("st_addr_ack", ack, 0);
        fork
            read_byte(1'b1, d);
            begin
                tick(500);
                bus.rd_data_i = 8'hC3; bus.rd_valid_i = 1'b1;
                wait_rdy();
                bus.rd_valid_i = 1'b0;
            end
        join
        bus_stop();
        tick(10);
        check("st_data", d, 8'hC3);
        check("st_stretch_ge_500", (max_run >= 500), 1);
        check("st_ready_count", n_rdy - s_rdy, 1);

        // Write to non-matching 0x23: NAK, SDA never pulled
        s_wr = n_wr; s_sda = n_sda_low;
        bus_start();
        write_byte({7'h23, I2C_OP_WRITE}, ack);
        check("nak_addr", ack, 1);
        bus_stop();
        tick(10);
        check("nak_no_wr_valid", n_wr - s_wr, 0);
        check("nak_sda_never_low", n_sda_low - s_sda, 0);

        // Address write, repeated START, read two bytes (ACK then NACK)
        s_start = n_start; s_rdy = n_rdy;
        bus_start();
        write_byte({7'h22, I2C_OP_WRITE}, ack);
        check("rs_wr_addr_ack", ack, 0);
        bus_start();
        write_byte({7'h22, I2C_OP_READ}, ack);
        check("rs_rd_addr_ack", ack, 0);
        fork
            begin
                read_byte(1'b0, d);
                read_byte(1'b1, d2);
            end
            begin
                bus.rd_data_i = 8'h11; bus.rd_valid_i = 1'b1;
                wait_rdy();
                bus.rd_data_i = 8'h22;
                wait_rdy();
                bus.rd_valid_i = 1'b0;
            end
        join
        check("rs_sda_released_after_nack", bus.sda_o, 1);
        bus_stop();
        tick(10);
        check("rs_byte0", d, 8'h11);
        check("rs_byte1", d2, 8'h22);
        check("rs_start_count", n_start - s_start, 2);
        check("rs_ready_count", n_rdy - s_rdy, 2);
        check("busy_clear_on_stop_cycle", n_busy_on_stop, 0);

        // One-cycle SDA glitch while SCL is high at idle
        s_start = n_start; s_stop = n_stop;
        sda_m = 1'b0; tick(1); sda_m = 1'b1; tick(30);
        check("glitch_no_start", n_start - s_start, 0);
        check("glitch_no_stop", n_stop - s_stop, 0);
        check("glitch_busy", bus.busy_o, 0);

        // Reset asserted while the target drives the address ACK
        bus_start();
        for (int i = 7; i >= 0; i--) write_bit(((8'h44 >> i) & 8'h01) != 0);
        sda_m = 1'b1; tick(Q); scl_m = 1'b1; wait_scl_high(); tick(Q);
        check("mid_ack_sda_low", bus.sda_o, 0);
        #2 rst = 1'b1;
        #1;
        check("arst_sda_o", bus.sda_o, 1);
        check("arst_scl_o", bus.scl_o, 1);
        check("arst_busy", bus.busy_o, 0);
        check("arst_state_idle", dut.state_q, ST_IDLE);
        tick(3);
        rst = 1'b0;
        s_start = n_start;
        tick(20);
        check("post_rst_no_start", n_start - s_start, 0);

        check("no_wait_timeout", n_timeout, 0);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
